// File: rtl/hex_seg_capture.sv
// hex_seg_capture: captures a pair of 7-segment digits, debounces
// them and presents the decoded byte over a valid/ready handshake.
module hex_seg_capture #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] hex0_in,
    input  logic [6:0] hex1_in,
    input  logic       ready,
    output logic [7:0] value,
    output logic       valid,
    output logic       err,
    output logic       overrun
);

    localparam logic [7:0] STABLE    = 8'(STABLE_CYCLES);
    localparam logic [7:0] STABLE_M1 = 8'(STABLE_CYCLES - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [13:0] sync1;
    logic [13:0] sync2;
    logic [13:0] prev;
    logic [13:0] last;
    logic        has_last;
    logic [7:0]  cnt;
    logic        changed;
    logic        accept;
    logic        good;
    logic        overrun_d;
    logic [4:0]  dec0;
    logic [4:0]  dec1;

    // Returns {decodable, nibble} for one active-low segment pattern.
    function automatic logic [4:0] decode(input logic [6:0] raw);
        logic [4:0] r;
        r = 5'b0_0000;
        case (~raw)
            7'b0111111: r = 5'h10;
            7'b0000110: r = 5'h11;
            7'b1011011: r = 5'h12;
            7'b1001111: r = 5'h13;
            7'b1100110: r = 5'h14;
            7'b1101101: r = 5'h15;
            7'b1111101: r = 5'h16;
            7'b0000111: r = 5'h17;
            7'b1111111: r = 5'h18;
            7'b1100111: r = 5'h19;
            7'b1110111: r = 5'h1A;
            7'b1111100: r = 5'h1B;
            7'b0111001: r = 5'h1C;
            7'b1011110: r = 5'h1D;
            7'b1111001: r = 5'h1E;
            7'b1110001: r = 5'h1F;
            default:    r = 5'h00;
        endcase
        return r;
    endfunction

    assign changed = (sync2 != prev);
    assign dec0    = decode(sync2[6:0]);
    assign dec1    = decode(sync2[13:7]);
    assign accept  = !changed && (cnt == STABLE_M1) &&
                     (!has_last || (sync2 != last));
    assign good    = accept && dec0[4] && dec1[4];
    assign valid   = (state_q == FULL);

    // Two-flop synchronizer; blank (all ones) out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '1;
            sync2 <= '1;
            prev  <= '1;
        end else begin
            sync1 <= {hex1_in, hex0_in};
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    // Stability counter: clears on any change, saturates at STABLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (changed) begin
            cnt <= '0;
        end else if (cnt != STABLE) begin
            cnt <= cnt + 8'd1;
        end
    end

    // Last accepted pair; forgotten once a different pair shows up so
    // the original can be accepted again after it returns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last     <= '1;
            has_last <= 1'b0;
        end else if (accept) begin
            last     <= sync2;
            has_last <= 1'b1;
        end else if (changed) begin
            has_last <= 1'b0;
        end
    end

    // Output state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and overrun detection.
    always_comb begin
        state_d   = state_q;
        overrun_d = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (good) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (good) begin
                    overrun_d = !ready;
                end else if (ready) begin
                    state_d = EMPTY;
                end
            end
        endcase
    end

    // Value register and one-cycle status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value   <= '0;
            err     <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (good) begin
                value <= {dec1[3:0], dec0[3:0]};
            end
            err     <= accept && !(dec0[4] && dec1[4]);
            overrun <= overrun_d;
        end
    end

endmodule

// File: tb/tb_hex_seg_capture.sv
// tb_hex_seg_capture: directed table plus hand-written sequences
// for hex_seg_capture with STABLE_CYCLES = 4.
module tb_hex_seg_capture;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] hex0_in = 7'h7F;
    logic [6:0] hex1_in = 7'h7F;
    logic       ready = 1'b0;
    logic [7:0] value;
    logic       valid;
    logic       err;
    logic       overrun;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [6:0] h1;
        logic [6:0] h0;
        logic       ev;
        logic [7:0] evalue;
        logic       eerr;
    } vec_t;

    vec_t       vecs[20];
    logic [6:0] seg[16];

    hex_seg_capture #(.STABLE_CYCLES(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .hex0_in (hex0_in),
        .hex1_in (hex1_in),
        .ready   (ready),
        .value   (value),
        .valid   (valid),
        .err     (err),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply(input int d1, input int d0);
        hex1_in = ~seg[d1];
        hex0_in = ~seg[d0];
    endtask

    task automatic consume();
        ready = 1'b1;
        step(1);
        ready = 1'b0;
        chk("consume_valid", {31'd0, valid}, 32'd0);
    endtask

    initial begin
        seg[0]  = 7'h3F; seg[1]  = 7'h06; seg[2]  = 7'h5B;
        seg[3]  = 7'h4F; seg[4]  = 7'h66; seg[5]  = 7'h6D;
        seg[6]  = 7'h7D; seg[7]  = 7'h07; seg[8]  = 7'h7F;
        seg[9]  = 7'h67; seg[10] = 7'h77; seg[11] = 7'h7C;
        seg[12] = 7'h39; seg[13] = 7'h5E; seg[14] = 7'h79;
        seg[15] = 7'h71;
        for (int i = 0; i < 16; i++) begin
            vecs[i] = '{~seg[i], ~seg[15 - i], 1'b1,
                        8'((i << 4) | (15 - i)), 1'b0};
        end
        vecs[16] = '{7'h7F,   ~seg[3],  1'b0, 8'hF0, 1'b1};
        vecs[17] = '{~seg[2], ~7'h01,   1'b0, 8'hF0, 1'b1};
        vecs[18] = '{~7'h7E,  ~seg[9],  1'b0, 8'hF0, 1'b1};
        vecs[19] = '{~seg[8], ~seg[0],  1'b1, 8'h80, 1'b0};

        // Reset with (3,0) already present.
        apply(3, 0);
        step(2);
        chk("rst_value", {24'd0, value}, 32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);
        rst_n = 1'b1;
        step(6);
        chk("r20_early", {31'd0, valid}, 32'd0);
        step(1);
        chk("r20_valid", {31'd0, valid}, 32'd1);
        chk("r20_value", {24'd0, value}, 32'h30);
        consume();

        // Table of settled pairs.
        for (int v = 0; v < 20; v++) begin
            hex1_in = vecs[v].h1;
            hex0_in = vecs[v].h0;
            step(6);
            chk("tbl_early_v", {31'd0, valid}, 32'd0);
            chk("tbl_early_e", {31'd0, err}, 32'd0);
            step(1);
            chk("tbl_valid", {31'd0, valid}, {31'd0, vecs[v].ev});
            chk("tbl_value", {24'd0, value}, {24'd0, vecs[v].evalue});
            chk("tbl_err", {31'd0, err}, {31'd0, vecs[v].eerr});
            consume();
            chk("tbl_err_clr", {31'd0, err}, 32'd0);
        end

        // Bouncing input never settles, then one acceptance.
        for (int c = 0; c < 10; c++) begin
            apply(1, (c % 2 == 0) ? 2 : 4);
            for (int k = 0; k < 2; k++) begin
                step(1);
                chk("bounce_v", {31'd0, valid}, 32'd0);
                chk("bounce_e", {31'd0, err}, 32'd0);
            end
        end
        apply(1, 2);
        step(7);
        chk("bounce_acc", {31'd0, valid}, 32'd1);
        chk("bounce_val", {24'd0, value}, 32'h12);
        consume();
        for (int k = 0; k < 10; k++) begin
            step(1);
            chk("no_reaccept", {31'd0, valid}, 32'd0);
        end

        // Undecodable digit held: single err pulse.
        hex1_in = ~seg[0];
        hex0_in = ~7'h01;
        step(6);
        chk("bad_early", {31'd0, err}, 32'd0);
        step(1);
        chk("bad_err", {31'd0, err}, 32'd1);
        chk("bad_valid", {31'd0, valid}, 32'd0);
        for (int k = 0; k < 10; k++) begin
            step(1);
            chk("bad_norepeat", {31'd0, err | valid}, 32'd0);
        end

        // Overrun when ready is held low.
        apply(10, 5);
        step(7);
        chk("a5_valid", {31'd0, valid}, 32'd1);
        chk("a5_value", {24'd0, value}, 32'hA5);
        apply(5, 10);
        step(6);
        chk("ovr_hold", {24'd0, value}, 32'hA5);
        chk("ovr_early", {31'd0, overrun}, 32'd0);
        step(1);
        chk("ovr_pulse", {31'd0, overrun}, 32'd1);
        chk("ovr_value", {24'd0, value}, 32'h5A);
        chk("ovr_valid", {31'd0, valid}, 32'd1);
        step(1);
        chk("ovr_clr", {31'd0, overrun}, 32'd0);
        consume();

        // Acceptance coinciding with ready.
        apply(1, 2);
        step(7);
        chk("co_first", {24'd0, value}, 32'h12);
        apply(3, 4);
        step(6);
        ready = 1'b1;
        step(1);
        ready = 1'b0;
        chk("co_value", {24'd0, value}, 32'h34);
        chk("co_valid", {31'd0, valid}, 32'd1);
        chk("co_overrun", {31'd0, overrun}, 32'd0);
        step(1);
        chk("co_still", {31'd0, valid}, 32'd1);
        consume();

        // Reset while holding a byte.
        apply(7, 7);
        step(7);
        chk("rr_valid", {31'd0, valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rr_zero_v", {31'd0, valid}, 32'd0);
        chk("rr_zero_d", {24'd0, value}, 32'd0);
        step(1);
        rst_n = 1'b1;
        step(6);
        chk("rr_early", {31'd0, valid}, 32'd0);
        step(1);
        chk("rr_again", {31'd0, valid}, 32'd1);
        chk("rr_value", {24'd0, value}, 32'h77);
        consume();

        // Transient different pair lets the original re-accept.
        apply(7, 6);
        step(1);
        apply(7, 7);
        step(6);
        chk("tr_early", {31'd0, valid}, 32'd0);
        step(1);
        chk("tr_valid", {31'd0, valid}, 32'd1);
        chk("tr_value", {24'd0, value}, 32'h77);
        consume();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
